// File: rtl/mem_arb_pkg.sv
// Shared types for the unified fetch/data memory port arbiter:
// FSM states, grant owner encoding and the default starvation limit.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IBUSY,
    DBUSY,
    RESP
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_owner_t;

  localparam int STARVE_DEF = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Consecutive data-grant counter; forces a fetch grant once data
// has won STARVE times in a row while a fetch was waiting.
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int STARVE = STARVE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_grant_d,
  input  logic i_grant_i,
  input  logic i_ireq,
  output logic o_force_i
);

  localparam logic [3:0] LIM = 4'(STARVE);

  logic [3:0] r_dcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dcnt <= 4'd0;
    end else if (i_grant_d && i_ireq) begin
      if (r_dcnt != LIM)
        r_dcnt <= r_dcnt + 4'd1;
    end else if (i_grant_d || i_grant_i) begin
      r_dcnt <= 4'd0;
    end
  end

  // Saturates at LIM, so "dcnt < STARVE" is simply !force
  assign o_force_i = (r_dcnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer sharing one handshaked memory between the
// fetch stage and the MEM stage; one transaction in flight at a time.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW     = 16,
  parameter int DW     = 32,
  parameter int STARVE = STARVE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_kill,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          if_stall,
  output logic          d_stall
);

  arb_state_t r_state;
  arb_owner_t r_owner;
  logic       r_killed;
  logic       r_i_ack;
  logic       r_d_ack;
  logic       r_m_req;
  logic       r_m_we;
  logic [AW-1:0] r_m_addr;
  logic [DW-1:0] r_m_wdata;
  logic [DW-1:0] r_i_rdata;
  logic [DW-1:0] r_d_rdata;

  logic w_idle;
  logic w_force_i;
  logic w_grant_d;
  logic w_grant_i;
  logic w_kill;

  assign w_idle    = (r_state == IDLE);
  assign w_grant_d = w_idle & d_req & (~i_req | ~w_force_i);
  assign w_grant_i = w_idle & ~w_grant_d & i_req & ~i_kill;
  // A kill in the completing cycle must already mask the ack
  assign w_kill    = r_killed | i_kill;

  arb_starve_cnt #(
    .STARVE(STARVE)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .i_grant_d(w_grant_d),
    .i_grant_i(w_grant_i),
    .i_ireq   (i_req),
    .o_force_i(w_force_i)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_owner   <= GRANT_I;
      r_killed  <= 1'b0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      unique case (r_state)
        IDLE: begin
          unique case (1'b1)
            w_grant_d: begin
              r_state   <= DBUSY;
              r_owner   <= GRANT_D;
              r_m_req   <= 1'b1;
              r_m_we    <= d_we;
              r_m_addr  <= d_addr;
              r_m_wdata <= d_wdata;
            end
            w_grant_i: begin
              r_state  <= IBUSY;
              r_owner  <= GRANT_I;
              r_m_req  <= 1'b1;
              r_m_we   <= 1'b0;
              r_m_addr <= i_addr;
            end
            default: ;
          endcase
        end
        IBUSY, DBUSY: begin
          if (r_owner == GRANT_I && i_kill)
            r_killed <= 1'b1;
          if (m_ack) begin
            r_state <= RESP;
            r_m_req <= 1'b0;
            r_m_we  <= 1'b0;
            if (r_owner == GRANT_D) begin
              r_d_ack <= 1'b1;
              if (!r_m_we)
                r_d_rdata <= m_rdata;
            end else if (!w_kill) begin
              r_i_ack   <= 1'b1;
              r_i_rdata <= m_rdata;
            end
          end
        end
        RESP: begin
          r_state  <= IDLE;
          r_killed <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign i_ack    = r_i_ack;
  assign d_ack    = r_d_ack;
  assign i_rdata  = r_i_rdata;
  assign d_rdata  = r_d_rdata;
  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign if_stall = i_req & ~i_ack;
  assign d_stall  = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios then
// randomized traffic against a transaction-level arbitration model.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_kill = 1'b0;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic          m_ack = 1'b0;
  logic          if_stall;
  logic          d_stall;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE(ST)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack),
    .if_stall(if_stall), .d_stall(d_stall)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_evt(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got none expected one", nm);
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem [int];
  logic [31:0] shadow [int];

  function automatic logic [31:0] init_val(input int a);
    return {16'hC0DE ^ a[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input int a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] shadow_rd(input int a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  int mem_wait = 0;
  int wcnt = 0;
  int wlim = 0;
  bit spur_en = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (m_req) begin
      if (wcnt == 0)
        wlim = (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
      if (wcnt == wlim) begin
        m_ack   = 1'b1;
        m_rdata = mem_rd(int'(m_addr));
        if (m_we) mem[int'(m_addr)] = m_wdata;
        wcnt = 0;
      end else begin
        m_ack   = 1'b0;
        m_rdata = $urandom;
        wcnt++;
      end
    end else begin
      wcnt    = 0;
      m_ack   = spur_en && ($urandom_range(0, 3) == 0);
      m_rdata = $urandom;
    end
  end

  // ---------------- scoreboard queues ----------------
  typedef struct {
    bit          we;
    logic [31:0] val;
  } dexp_t;

  logic [31:0] i_exp_q [$];
  dexp_t       d_exp_q [$];

  // ---------------- drivers ----------------
  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [15:0] a, input int kill_at);
    int n;
    bit done;
    n = 0;
    done = 0;
    i_req  = 1'b1;
    i_addr = a;
    i_exp_q.push_back(mem_rd(int'(a)));
    while (!done) begin
      @(posedge clk);
      #1;
      n++;
      if (i_ack) begin
        i_req = 1'b0;
        done = 1;
      end else if (n == kill_at) begin
        i_kill = 1'b1;
        i_req  = 1'b0;
        if (i_exp_q.size() > 0)
          i_exp_q.delete(i_exp_q.size() - 1);
        @(posedge clk);
        #1;
        i_kill = 1'b0;
        done = 1;
      end else if (n > 100) begin
        fail_evt("fetch_ack_timeout");
        i_req = 1'b0;
        done = 1;
      end
    end
  endtask

  task automatic do_data(input bit we, input logic [15:0] a,
                         input logic [31:0] wd);
    dexp_t e;
    int n;
    e.we = we;
    if (we) begin
      shadow[int'(a)] = wd;
      e.val = '0;
    end else begin
      e.val = shadow_rd(int'(a));
    end
    d_exp_q.push_back(e);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!d_ack && n <= 100);
    if (!d_ack) fail_evt("data_ack_timeout");
    d_req = 1'b0;
  endtask

  // ---------------- monitor / reference model ----------------
  logic        pm_req, pm_ack, p_ireq, p_dreq, p_kill, p_dwe;
  logic [15:0] p_iaddr, p_daddr, acc_addr;
  logic [31:0] p_dwdata, acc_wdata, i_hold, d_hold;
  bit          idle_prev, acc_d, acc_killed, acc_we;
  bit          resp_now, gd, gi;
  int          mcnt;
  bit          glog [$];
  dexp_t       de;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      pm_req = 0; pm_ack = 0; p_ireq = 0; p_dreq = 0;
      p_kill = 0; p_dwe = 0; p_iaddr = '0; p_daddr = '0;
      p_dwdata = '0; i_hold = '0; d_hold = '0;
      idle_prev = 1; acc_d = 0; acc_killed = 0; mcnt = 0;
      i_exp_q.delete();
      d_exp_q.delete();
    end else begin
      resp_now = pm_req && pm_ack;
      if (idle_prev) begin
        gd = p_dreq && (!p_ireq || mcnt < ST);
        gi = !gd && p_ireq && !p_kill;
        chk("grant_taken", m_req, gd || gi);
        if (m_req && (gd || gi)) begin
          glog.push_back(m_addr >= 16'h0100);
          if (gd) begin
            chk("grant_d_addr", m_addr, p_daddr);
            chk("grant_d_we", m_we, p_dwe);
            if (p_dwe) chk("grant_d_wdata", m_wdata, p_dwdata);
            mcnt = p_ireq ? ((mcnt < ST) ? mcnt + 1 : ST) : 0;
          end else begin
            chk("grant_i_addr", m_addr, p_iaddr);
            chk("grant_i_we", m_we, 0);
            mcnt = 0;
          end
          acc_d = gd;
          acc_killed = 0;
          acc_addr = m_addr;
          acc_we = m_we;
          acc_wdata = m_wdata;
        end
      end else if (pm_req && !pm_ack) begin
        chk("busy_m_req_held", m_req, 1);
        chk("busy_m_addr_stable", m_addr, acc_addr);
        chk("busy_m_we_stable", m_we, acc_we);
        chk("busy_m_wdata_stable", m_wdata, acc_wdata);
      end else begin
        chk("no_grant_outside_idle", m_req, 0);
      end
      if (m_req && !acc_d && i_kill) acc_killed = 1;
      if (resp_now) begin
        chk("resp_m_we", m_we, 0);
        if (acc_d) begin
          chk("resp_d_ack", d_ack, 1);
          chk("resp_d_no_i_ack", i_ack, 0);
          if (d_exp_q.size() == 0) fail_evt("d_scoreboard_entry");
          else begin
            de = d_exp_q.pop_front();
            if (!de.we) d_hold = de.val;
          end
        end else if (!acc_killed) begin
          chk("resp_i_ack", i_ack, 1);
          chk("resp_i_no_d_ack", d_ack, 0);
          if (i_exp_q.size() == 0) fail_evt("i_scoreboard_entry");
          else i_hold = i_exp_q.pop_front();
        end else begin
          chk("killed_i_ack", i_ack, 0);
          chk("killed_d_ack", d_ack, 0);
        end
      end else begin
        chk("i_ack_not_resp", i_ack, 0);
        chk("d_ack_not_resp", d_ack, 0);
      end
      chk("i_rdata", i_rdata, i_hold);
      chk("d_rdata", d_rdata, d_hold);
      chk("if_stall", if_stall, i_req & ~i_ack);
      chk("d_stall", d_stall, d_req & ~d_ack);
      idle_prev = !m_req && !resp_now;
      pm_req = m_req; pm_ack = m_ack;
      p_ireq = i_req; p_dreq = d_req; p_kill = i_kill;
      p_iaddr = i_addr; p_daddr = d_addr;
      p_dwe = d_we; p_dwdata = d_wdata;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_m_req"}, m_req, 0);
    chk({tag, "_m_we"}, m_we, 0);
    chk({tag, "_i_ack"}, i_ack, 0);
    chk({tag, "_d_ack"}, d_ack, 0);
    chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_m_wdata"}, m_wdata, 0);
    chk({tag, "_i_rdata"}, i_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  bit pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected one");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    #22;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // single fetch, zero wait
    mem[4] = 32'h00500093;
    gap(1);
    do_fetch(16'h0004, -1);
    chk("single_fetch_rdata", i_rdata, 32'h00500093);
    gap(2);
    chk("single_fetch_hold", i_rdata, 32'h00500093);

    // collision: store wins, fetch follows
    fork
      do_fetch(16'h0008, -1);
      do_data(1'b1, 16'h0100, 32'hDEADBEEF);
    join
    chk("collision_store_mem", mem_rd(32'h100), 32'hDEADBEEF);

    // wait states on a load
    gap(2);
    mem_wait = 2;
    do_data(1'b0, 16'h0200, 32'h0);
    mem_wait = 0;

    // starvation: D D I D D I
    gap(2);
    glog.delete();
    fork
      repeat (4) do_data(1'b0, 16'h0104, 32'h0);
      repeat (2) do_fetch(16'h000C, -1);
    join
    chk("starve_count", glog.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < glog.size())
        chk($sformatf("starve_order_%0d", k), glog[k], pat[k]);

    // kill in the second IBUSY cycle, 3-wait memory
    gap(2);
    mem_wait = 3;
    fork
      do_fetch(16'h0030, 2);
      begin
        gap(2);
        do_data(1'b0, 16'h0110, 32'h0);
      end
    join
    mem_wait = 0;

    // reset mid-DBUSY with the starvation counter saturated
    gap(2);
    i_req = 1'b1; i_addr = 16'h0020;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0104;
    d_exp_q.push_back('{we: 1'b0, val: shadow_rd(32'h104)});
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!d_ack && n < 50);
    if (!d_ack) fail_evt("reset_setup_ack");
    mem_wait = 6;
    d_we = 1'b1; d_addr = 16'h0108; d_wdata = 32'h12345678;
    d_exp_q.push_back('{we: 1'b1, val: 32'h0});
    repeat (3) @(posedge clk);
    #3;
    chk("pre_reset_m_req", m_req, 1);
    rst = 1'b0;
    #1;
    chk_zero("async_reset");
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("held_reset");
    rst = 1'b1;
    mem_wait = 0;
    gap(1);
    fork
      do_fetch(16'h0024, -1);
      do_data(1'b0, 16'h010C, 32'h0);
    join

    // randomized traffic
    gap(2);
    spur_en = 1;
    mem_wait = -1;
    fork
      begin : fdrv
        logic [15:0] a;
        int k;
        repeat (60) begin
          gap($urandom_range(0, 3));
          a = 16'($urandom_range(0, 63) * 4);
          k = ($urandom_range(0, 4) == 0) ?
              int'($urandom_range(1, 4)) : -1;
          do_fetch(a, k);
        end
      end
      begin : ddrv
        logic [15:0] a;
        repeat (60) begin
          gap($urandom_range(0, 3));
          a = 16'(16'h0100 + $urandom_range(0, 15) * 4);
          do_data(1'($urandom_range(0, 1)), a, $urandom);
        end
      end
    join
    gap(6);
    chk("i_queue_drained", i_exp_q.size(), 0);
    chk("d_queue_drained", d_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter and sequencer that shares one single-port, handshaked 32-bit memory between the fetch stage (instruction reads) and the MEM stage (data loads/stores) of the 5-stage RISC-V pipeline. It replaces the separate instruction and data memories with a unified memory. It grants one transaction at a time and carries it through a request/acknowledge handshake. It also exports stall qualifiers that the pipeline control combines into the `if_we` and pipeline-freeze signals.

## Interface
- `AW`, default 16: memory address width (byte address, same width the fetch path uses).
- `DW`, default 32: data width.
- `STARVE`, default 4: maximum consecutive data grants while a fetch is pending; range 1..15.

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `i_req`  in  1: fetch request; held until `i_ack` or `i_kill`.
- `i_addr`  in  AW: fetch address.
- `i_kill`  in  1: flush of the outstanding fetch (branch/jump taken).
- `i_ack`  out  1: one-cycle fetch completion pulse.
- `i_rdata`  out  DW: fetched instruction; registered, holds until the next `i_ack`.
- `d_req`  in  1: data request; held until `d_ack`.
- `d_we`  in  1: 1 = store, 0 = load.
- `d_addr`  in  AW: data address.
- `d_wdata`  in  DW: store data.
- `d_ack`  out  1: one-cycle data completion pulse.
- `d_rdata`  out  DW: load data; registered, holds until the next `d_ack`.
- `m_req`  out  1: memory request.
- `m_we`  out  1: memory write enable.
- `m_addr`  out  AW: memory address.
- `m_wdata`  out  DW: memory write data.
- `m_rdata`  in  DW: memory read data, valid when `m_ack` = 1.
- `m_ack`  in  1: memory completion; sampled only while `m_req` = 1.
- `if_stall`  out  1: `i_req & ~i_ack`, combinational.
- `d_stall`  out  1: `d_req & ~d_ack`, combinational.

## Operation
- FSM states: IDLE, IBUSY, DBUSY, RESP.
- **IDLE**
  - If `d_req` and (`!i_req` or `dcnt < STARVE`), grant data: capture `d_addr`/`d_we`/`d_wdata` into the `m_*` registers and go to DBUSY.
  - Otherwise, if `i_req` and `!i_kill`, grant fetch: capture `i_addr` with `m_we` = 0 and go to IBUSY.
  - Otherwise stay in IDLE.
- **IBUSY / DBUSY**
  - `m_req` = 1. `m_addr`, `m_we` and `m_wdata` stay frozen at their captured values.
  - On `m_ack`, go to RESP. The completing port's rdata register loads `m_rdata`. Loads and fetches capture data; stores leave `d_rdata` unchanged.
- **RESP**
  - `m_req` = 0 and `m_we` = 0.
  - Exactly one of `i_ack`/`d_ack` is 1, matching the completed grant.
  - No new grant is made; next state is IDLE. This gives the requester one cycle to drop or change its request.
- **Kill**
  - `i_kill` at any cycle during IBUSY sets a sticky `killed` flag.
  - The memory transaction still completes; `m_req` is never withdrawn before `m_ack`.
  - In RESP, `i_ack` is suppressed and `i_rdata` is not updated. The flag clears on the IDLE transition.
  - `i_kill` in IDLE blocks a fetch grant in that cycle only.
- **Starvation counter `dcnt`** (4 bits)
  - On a data grant with `i_req` = 1: increment, saturating at `STARVE`.
  - On a data grant with `i_req` = 0, or on any fetch grant: clear to 0.
- A store and a fetch are never in flight together; the memory sees strictly serialized accesses.
- Reset, asynchronous, takes effect immediately, including mid-transaction:
  - state = IDLE and `killed` = 0;
  - `m_req`, `m_we`, `i_ack`, `d_ack` = 0;
  - `m_addr`, `m_wdata`, `i_rdata`, `d_rdata` = 0;
  - `dcnt` = 0.

## Timing
- All outputs except `if_stall`/`d_stall` are registered.
- Minimum transaction (zero-wait memory, `m_ack` in the first `m_req` cycle):
  - request seen in IDLE at edge 0;
  - `m_req` high in cycle 1;
  - ack pulse in cycle 2;
  - IDLE in cycle 3.
  - Latency is 2 cycles from grant edge to ack; peak throughput is one access per 3 cycles.
- Each memory wait state adds one BUSY cycle.
- Simultaneous requests in IDLE: data wins unless `dcnt == STARVE`, in which case fetch wins.
- `m_ack` while `m_req` = 0 is ignored.

## Structure
- Shared package `mem_arb_pkg`: the state enum (IDLE, IBUSY, DBUSY, RESP), a `GRANT_I`/`GRANT_D` owner encoding, and default `STARVE`.
- One natural sub-module: `arb_starve_cnt`, the saturating/clearing counter that outputs `force_i`.

## Test plan
- Single fetch: `i_req`, `i_addr` = 0x0004, memory returns 0x00500093 with zero wait.
  - Expect `m_req` high exactly 1 cycle.
  - Expect `i_ack` one cycle, 2 cycles after the grant edge, with `i_rdata` = 0x00500093, then held.
- Collision: `i_req` (0x0008) and a store (`d_addr` = 0x0100, `d_wdata` = 0xDEADBEEF) in the same cycle.
  - Data granted first with `m_we` = 1 and `m_addr` = 0x0100.
  - Fetch granted in the first IDLE after `d_ack`.
  - `d_rdata` unchanged.
- Starvation with `STARVE` = 2 and `i_req`, `d_req` held continuously (requesters re-request after each ack).
  - Grant order D, D, I, D, D, I.
- Kill with 3-wait memory: `i_kill` in the second IBUSY cycle.
  - `m_req` stays high until `m_ack`.
  - No `i_ack`; `i_rdata` keeps its old value.
  - A pending `d_req` is granted in the following IDLE.
- Wait states: `m_ack` delayed 2 cycles on a load from 0x0200.
  - `m_addr` stable at 0x0200 throughout.
  - `d_stall` high until the `d_ack` cycle, low in it.
- Reset mid-DBUSY: drive `rst` = 0 between edges.
  - `m_req`, `m_we` = 0 immediately, before the next edge.
  - All registered outputs and `dcnt` = 0.
  - After release, a fresh `i_req` is granted normally.
